pll_acquisition_controller: RTL and testbench
=============================================

PLL_ACQUISITION_CONTROLLER -- requirements
Module: pll_acquisition_controller

Interface
REQ-001 Parameter FW, default 32: NCO frequency-word width.
REQ-002 Parameter LOCK_COUNT, default 1024: consecutive in-threshold cycles required to declare lock.
REQ-003 Parameter LOSS_COUNT, default 64: consecutive out-of-threshold cycles required to declare loss of lock.
REQ-004 clock  in  1  single system clock; all logic on its rising edge.
REQ-005 Reset  in  1  synchronous, active-low reset.
REQ-006 Start  in  1  one-cycle request to begin acquisition; honoured only in IDLE or FAIL.
REQ-007 Stop  in  1  abort; returns to IDLE from any state.
REQ-008 Sweep_Start, Sweep_Stop, Sweep_Step  in  FW each  sweep bounds and increment, in NCO frequency-word units.
REQ-009 Settle_Cycles  in  16  wait after each NCO retune before measuring.
REQ-010 Amplitude, Amp_Threshold  in  16 each  phase-detector magnitude (unsigned) and detection threshold.
REQ-011 Freq_Measured  in  FW  frequency-counter result.
REQ-012 NCO_Freq  out  FW  base frequency word for the NCO.
REQ-013 Loop_Enable  out  1  enables the loop filter correction.
REQ-014 Locked, Busy, Fail  out  1 each  status flags.
REQ-015 Lock_Freq  out  FW  Freq_Measured captured on lock.
REQ-016 State  out  3  current state encoding: IDLE=0, SETTLE=1, MEASURE=2, TRACK=3, LOCKED=4, FAIL=5.

Function
REQ-017 Start in IDLE/FAIL latches Sweep_Start/Stop/Step, Settle_Cycles and Amp_Threshold into internal registers; later changes to these inputs have no effect until the next Start.
REQ-018 Start with Sweep_Step=0 or Sweep_Start>Sweep_Stop goes directly to FAIL on the next cycle.
REQ-019 Otherwise Start sets NCO_Freq=Sweep_Start, loads the settle counter with max(Settle_Cycles,1), and enters SETTLE on the next edge.
REQ-020 SETTLE decrements the counter once per cycle and enters MEASURE on the cycle after the counter reaches 1; dwell is exactly max(Settle_Cycles,1) cycles.
REQ-021 MEASURE lasts one cycle; if Amplitude>=Amp_Threshold, enter TRACK; otherwise compute NCO_Freq+Step with an FW+1-bit sum.
REQ-022 On MEASURE failure, a carry out or a sum greater than Sweep_Stop enters FAIL and leaves NCO_Freq unchanged; otherwise NCO_Freq takes the sum, the settle counter reloads and the block returns to SETTLE.
REQ-023 A sum exactly equal to Sweep_Stop is a valid final step.
REQ-024 TRACK: Loop_Enable=1; a lock counter increments each cycle with Amplitude>=threshold and clears to 0 on any cycle below threshold.
REQ-025 When the lock counter reaches LOCK_COUNT-1 with an in-threshold cycle, enter LOCKED; Lock_Freq captures Freq_Measured on that edge.
REQ-026 LOCKED: Locked=1, Loop_Enable=1; a loss counter increments on each below-threshold cycle and clears on any in-threshold cycle.
REQ-027 When the loss counter reaches LOSS_COUNT: Locked=0 and Loop_Enable=0 on the next edge, NCO_Freq reloads Sweep_Start, and the block re-enters SETTLE (automatic reacquisition); Lock_Freq holds its value.
REQ-028 FAIL: Fail=1, Loop_Enable=0, NCO_Freq holds; Start clears Fail and proceeds per REQ-018/019.
REQ-029 Busy=1 in SETTLE, MEASURE and TRACK; 0 otherwise.
REQ-030 Stop takes effect on the next edge in every state: enter IDLE, Loop_Enable=0, Locked=0, Fail=0; NCO_Freq and Lock_Freq hold.
REQ-031 Stop and Start asserted in the same cycle: Stop wins.
REQ-032 Start outside IDLE/FAIL is ignored.
REQ-033 All outputs are registered; no combinational input-to-output path.

Reset
REQ-034 Reset=0 sampled on a rising edge forces IDLE with NCO_Freq=0, Lock_Freq=0, Loop_Enable=0, Locked=0, Busy=0, Fail=0, State=0, and all counters at 0; this applies mid-operation and overrides Start and Stop.
REQ-035 Reset=1 resumes normal operation on the following edge, in IDLE.

Verification
REQ-036 Start=100, Stop=130, Step=10, Settle=4, Thr=500; Amplitude=600 only while NCO_Freq=120 -> NCO_Freq steps 100,110,120 at 5-cycle intervals (4 SETTLE + 1 MEASURE), then TRACK and LOCKED after LOCK_COUNT cycles with Lock_Freq=Freq_Measured.
REQ-037 Same sweep with Amplitude always 0 -> NCO_Freq ends at 130, then FAIL with Fail=1 and Busy=0; the sweep never exceeds Sweep_Stop.
REQ-038 Start=0xFFFFFFF0, Stop=0xFFFFFFFF, Step=0x20, no signal -> carry detected on the first MEASURE, FAIL, NCO_Freq stays 0xFFFFFFF0.
REQ-039 In LOCKED, drive Amplitude below threshold for LOSS_COUNT-1 cycles, then one cycle above -> remains LOCKED; then LOSS_COUNT cycles below -> Locked=0, SETTLE, NCO_Freq=Sweep_Start.
REQ-040 Stop and Start in the same cycle while in TRACK -> IDLE next edge; separately, Reset=0 during SETTLE -> all outputs at REQ-034 values next edge.

Source files
------------

// File: rtl/pll_acquisition_controller.sv
// pll_acquisition_controller: sweeps an NCO frequency word from Sweep_Start to
// Sweep_Stop in Sweep_Step increments. After each retune it waits Settle_Cycles,
// then measures the phase-detector amplitude. It enters tracking when the signal
// is detected, declares lock after LOCK_COUNT consecutive good cycles, and
// reacquires automatically after LOSS_COUNT consecutive bad cycles.
// Latency: every state change and output update takes effect one clock edge after
// the input that caused it. All outputs come from registers.
// Backpressure: none. Start is honoured only in IDLE or FAIL. Stop overrides Start,
// and Reset overrides both.
//
// Ports:
//   i_clk, i_rst_n (synchronous, active-low)
//   i_start, i_stop                               control pulses
//   i_sweep_start/stop/step [FW], i_settle_cycles sweep configuration, latched on Start
//   i_amplitude, i_amp_threshold [16]             detector magnitude and threshold
//   i_freq_measured [FW]                          frequency counter, captured on lock
//   o_nco_freq [FW], o_loop_enable, o_locked, o_busy, o_fail, o_lock_freq [FW], o_state [3]
module pll_acquisition_controller #(
  parameter int FW         = 32,
  parameter int LOCK_COUNT = 1024,
  parameter int LOSS_COUNT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [FW-1:0] i_sweep_start,
  input  logic [FW-1:0] i_sweep_stop,
  input  logic [FW-1:0] i_sweep_step,
  input  logic [15:0]   i_settle_cycles,
  input  logic [15:0]   i_amplitude,
  input  logic [15:0]   i_amp_threshold,
  input  logic [FW-1:0] i_freq_measured,
  output logic [FW-1:0] o_nco_freq,
  output logic          o_loop_enable,
  output logic          o_locked,
  output logic          o_busy,
  output logic          o_fail,
  output logic [FW-1:0] o_lock_freq,
  output logic [2:0]    o_state
);

  localparam int LKW = $clog2(LOCK_COUNT + 1);
  localparam int LSW = $clog2(LOSS_COUNT + 1);
  localparam logic [LKW-1:0] LOCK_LAST = LKW'(LOCK_COUNT - 1);
  localparam logic [LSW-1:0] LOSS_LAST = LSW'(LOSS_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_TRACK   = 3'd3,
    S_LOCKED  = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  state_t         r_state, w_state;
  logic [FW-1:0]  r_nco, w_nco;
  logic [FW-1:0]  r_lock_freq, w_lock_freq;
  logic [FW-1:0]  r_sw_start, w_sw_start;
  logic [FW-1:0]  r_sw_stop, w_sw_stop;
  logic [FW-1:0]  r_sw_step, w_sw_step;
  logic [15:0]    r_settle, w_settle;      // holds max(Settle_Cycles,1), the reload value
  logic [15:0]    r_thr, w_thr;
  logic [15:0]    r_settle_cnt, w_settle_cnt;
  logic [LKW-1:0] r_lock_cnt, w_lock_cnt;
  logic [LSW-1:0] r_loss_cnt, w_loss_cnt;

  logic           w_amp_ok;
  logic [FW:0]    w_sum;                   // one extra bit so a wrap past 2^FW is visible
  logic [15:0]    w_settle_in;

  assign w_amp_ok    = (i_amplitude >= r_thr);
  assign w_sum       = {1'b0, r_nco} + {1'b0, r_sw_step};
  assign w_settle_in = (i_settle_cycles == 16'd0) ? 16'd1 : i_settle_cycles;

  always_comb begin
    w_state      = r_state;
    w_nco        = r_nco;
    w_lock_freq  = r_lock_freq;
    w_sw_start   = r_sw_start;
    w_sw_stop    = r_sw_stop;
    w_sw_step    = r_sw_step;
    w_settle     = r_settle;
    w_thr        = r_thr;
    w_settle_cnt = r_settle_cnt;
    w_lock_cnt   = r_lock_cnt;
    w_loss_cnt   = r_loss_cnt;

    case (r_state)
      S_IDLE, S_FAIL: begin
        if (i_start) begin
          w_sw_start = i_sweep_start;
          w_sw_stop  = i_sweep_stop;
          w_sw_step  = i_sweep_step;
          w_settle   = w_settle_in;
          w_thr      = i_amp_threshold;
          w_lock_cnt = '0;
          w_loss_cnt = '0;
          // The configuration is validated on the raw inputs because they are
          // latched on this same edge.
          if (i_sweep_step == '0 || i_sweep_start > i_sweep_stop) begin
            w_state = S_FAIL;
          end else begin
            w_nco        = i_sweep_start;
            w_settle_cnt = w_settle_in;
            w_state      = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt <= 16'd1) begin
          w_settle_cnt = '0;
          w_state      = S_MEASURE;
        end else begin
          w_settle_cnt = r_settle_cnt - 16'd1;
        end
      end
      S_MEASURE: begin
        if (w_amp_ok) begin
          w_lock_cnt = '0;
          w_state    = S_TRACK;
        end else if (w_sum[FW] || (w_sum[FW-1:0] > r_sw_stop)) begin
          w_state = S_FAIL;          // the NCO word stays at the last valid step
        end else begin
          w_nco        = w_sum[FW-1:0];
          w_settle_cnt = r_settle;
          w_state      = S_SETTLE;
        end
      end
      S_TRACK: begin
        if (w_amp_ok) begin
          if (r_lock_cnt == LOCK_LAST) begin
            w_lock_freq = i_freq_measured;
            w_lock_cnt  = '0;
            w_loss_cnt  = '0;
            w_state     = S_LOCKED;
          end else begin
            w_lock_cnt = r_lock_cnt + 1'b1;
          end
        end else begin
          w_lock_cnt = '0;
        end
      end
      S_LOCKED: begin
        if (!w_amp_ok) begin
          if (r_loss_cnt == LOSS_LAST) begin
            // Automatic reacquisition restarts the sweep from the bottom.
            w_nco        = r_sw_start;
            w_settle_cnt = r_settle;
            w_loss_cnt   = '0;
            w_state      = S_SETTLE;
          end else begin
            w_loss_cnt = r_loss_cnt + 1'b1;
          end
        end else begin
          w_loss_cnt = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Stop overrides everything else, including a simultaneous Start, so any
    // configuration latched by that Start is discarded.
    if (i_stop) begin
      w_state      = S_IDLE;
      w_nco        = r_nco;
      w_lock_freq  = r_lock_freq;
      w_sw_start   = r_sw_start;
      w_sw_stop    = r_sw_stop;
      w_sw_step    = r_sw_step;
      w_settle     = r_settle;
      w_thr        = r_thr;
      w_settle_cnt = '0;
      w_lock_cnt   = '0;
      w_loss_cnt   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_nco        <= '0;
      r_lock_freq  <= '0;
      r_sw_start   <= '0;
      r_sw_stop    <= '0;
      r_sw_step    <= '0;
      r_settle     <= '0;
      r_thr        <= '0;
      r_settle_cnt <= '0;
      r_lock_cnt   <= '0;
      r_loss_cnt   <= '0;
    end else begin
      r_state      <= w_state;
      r_nco        <= w_nco;
      r_lock_freq  <= w_lock_freq;
      r_sw_start   <= w_sw_start;
      r_sw_stop    <= w_sw_stop;
      r_sw_step    <= w_sw_step;
      r_settle     <= w_settle;
      r_thr        <= w_thr;
      r_settle_cnt <= w_settle_cnt;
      r_lock_cnt   <= w_lock_cnt;
      r_loss_cnt   <= w_loss_cnt;
    end
  end

  // Status flags are pure decodes of the state register, so no input reaches an
  // output without passing through a flop.
  assign o_state       = r_state;
  assign o_nco_freq    = r_nco;
  assign o_lock_freq   = r_lock_freq;
  assign o_loop_enable = (r_state == S_TRACK) || (r_state == S_LOCKED);
  assign o_locked      = (r_state == S_LOCKED);
  assign o_fail        = (r_state == S_FAIL);
  assign o_busy        = (r_state == S_SETTLE) || (r_state == S_MEASURE) || (r_state == S_TRACK);

endmodule

// File: tb/tb_pll_acquisition_controller.sv
// Testbench for pll_acquisition_controller, built with LOCK_COUNT=8 and LOSS_COUNT=4.
// Table-driven single-cycle vectors, followed by hand-written sweep, lock,
// loss, carry and reset sequences.
module tb_pll_acquisition_controller;

  localparam int FW = 32;
  localparam int LC = 8;
  localparam int LS = 4;
  localparam logic [2:0] IDLE = 3'd0, SETTLE = 3'd1, MEASURE = 3'd2,
                         TRACK = 3'd3, LOCKED = 3'd4, FAILS = 3'd5;
  localparam logic [31:0] FMEAS = 32'hCAFE_0120;

  logic          i_clk = 1'b0;
  logic          i_rst_n, i_start, i_stop;
  logic [FW-1:0] i_sweep_start, i_sweep_stop, i_sweep_step, i_freq_measured;
  logic [15:0]   i_settle_cycles, i_amplitude, i_amp_threshold;
  logic [FW-1:0] o_nco_freq, o_lock_freq;
  logic          o_loop_enable, o_locked, o_busy, o_fail;
  logic [2:0]    o_state;

  int checks = 0;
  int failures = 0;

  pll_acquisition_controller #(.FW(FW), .LOCK_COUNT(LC), .LOSS_COUNT(LS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_sweep_start(i_sweep_start), .i_sweep_stop(i_sweep_stop), .i_sweep_step(i_sweep_step),
    .i_settle_cycles(i_settle_cycles), .i_amplitude(i_amplitude),
    .i_amp_threshold(i_amp_threshold), .i_freq_measured(i_freq_measured),
    .o_nco_freq(o_nco_freq), .o_loop_enable(o_loop_enable), .o_locked(o_locked),
    .o_busy(o_busy), .o_fail(o_fail), .o_lock_freq(o_lock_freq), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        st, sp;
    logic [31:0] s0, s1, stp;
    logic [15:0] set, amp, thr;
    logic [2:0]  e_state;
    logic [31:0] e_nco;
    logic        e_fail, e_busy, e_le;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cfg(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] stp,
                     input logic [15:0] set, input logic [15:0] thr);
    i_sweep_start = s0; i_sweep_stop = s1; i_sweep_step = stp;
    i_settle_cycles = set; i_amp_threshold = thr;
  endtask

  // Checks one full dwell: four SETTLE samples at the given NCO word, then one MEASURE sample.
  task automatic dwell(input logic [31:0] nco, input string tag);
    for (int j = 0; j < 4; j++) begin
      chk({tag, "_settle_state"}, 32'(o_state), 32'(SETTLE));
      chk({tag, "_settle_nco"}, o_nco_freq, nco);
      tick();
    end
    chk({tag, "_measure_state"}, 32'(o_state), 32'(MEASURE));
    chk({tag, "_measure_nco"}, o_nco_freq, nco);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_amplitude = 16'd0;
    i_freq_measured = FMEAS;
    cfg(32'd0, 32'd0, 32'd0, 16'd0, 16'd0);

    // Reset values
    tick(); tick();
    chk("rst_state", 32'(o_state), 32'(IDLE));
    chk("rst_nco", o_nco_freq, 32'd0);
    chk("rst_lockf", o_lock_freq, 32'd0);
    chk("rst_flags", {28'd0, o_loop_enable, o_locked, o_busy, o_fail}, 32'd0);
    i_rst_n = 1'b1;
    tick();
    chk("rst_release_idle", 32'(o_state), 32'(IDLE));

    //           st   sp    s0     s1     stp    set    amp      thr      state    nco    f     b     le
    vecs[0]  = '{1'b1,1'b0,32'd5, 32'd9, 32'd0, 16'd2, 16'd0,   16'd100, FAILS,  32'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1,1'b0,32'd9, 32'd5, 32'd1, 16'd2, 16'd0,   16'd100, FAILS,  32'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1,1'b0,32'd5, 32'd9, 32'd2, 16'd0, 16'd0,   16'd100, SETTLE, 32'd5, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0,1'b0,32'd5, 32'd9, 32'd2, 16'd0, 16'd0,   16'd100, MEASURE,32'd5, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0,1'b0,32'd5, 32'd9, 32'd2, 16'd0, 16'd0,   16'd100, SETTLE, 32'd7, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0,1'b0,32'd5, 32'd9, 32'd2, 16'd0, 16'd0,   16'd100, MEASURE,32'd7, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0,1'b0,32'd5, 32'd9, 32'd2, 16'd0, 16'd100, 16'd999, TRACK,  32'd7, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1,1'b0,32'd0, 32'd0, 32'd1, 16'd0, 16'd100, 16'd999, TRACK,  32'd7, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1,1'b1,32'd0, 32'd0, 32'd1, 16'd0, 16'd100, 16'd999, IDLE,   32'd7, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1,1'b0,32'd0, 32'd0, 32'd1, 16'd1, 16'd0,   16'd0,   SETTLE, 32'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0,1'b0,32'd0, 32'd0, 32'd1, 16'd1, 16'd0,   16'd0,   MEASURE,32'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0,1'b0,32'd0, 32'd0, 32'd1, 16'd1, 16'd0,   16'd0,   TRACK,  32'd0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0,1'b1,32'd0, 32'd0, 32'd1, 16'd1, 16'd0,   16'd0,   IDLE,   32'd0, 1'b0, 1'b0, 1'b0};

    for (int v = 0; v < 13; v++) begin
      i_start = vecs[v].st; i_stop = vecs[v].sp; i_amplitude = vecs[v].amp;
      cfg(vecs[v].s0, vecs[v].s1, vecs[v].stp, vecs[v].set, vecs[v].thr);
      tick();
      chk($sformatf("vec%0d_state", v), 32'(o_state), 32'(vecs[v].e_state));
      chk($sformatf("vec%0d_nco", v), o_nco_freq, vecs[v].e_nco);
      chk($sformatf("vec%0d_fail", v), 32'(o_fail), 32'(vecs[v].e_fail));
      chk($sformatf("vec%0d_busy", v), 32'(o_busy), 32'(vecs[v].e_busy));
      chk($sformatf("vec%0d_le", v), 32'(o_loop_enable), 32'(vecs[v].e_le));
    end
    i_start = 1'b0; i_stop = 1'b0;

    // Sweep 100..130 step 10: signal present only at 120, then track and lock.
    cfg(32'd100, 32'd130, 32'd10, 16'd4, 16'd500);
    i_amplitude = 16'd0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cfg(32'd7, 32'd1000, 32'd99, 16'd9, 16'd9000);   // must be ignored until the next Start
    for (int k = 0; k < 3; k++) begin
      i_amplitude = (k == 2) ? 16'd600 : 16'd0;
      dwell(32'd100 + 32'(10 * k), $sformatf("swA%0d", k));
      tick();
    end
    for (int j = 0; j < LC; j++) begin
      chk("track_state", 32'(o_state), 32'(TRACK));
      chk("track_le_busy", {30'd0, o_loop_enable, o_busy}, 32'd3);
      tick();
    end
    chk("lock_state", 32'(o_state), 32'(LOCKED));
    chk("lock_flags", {29'd0, o_locked, o_loop_enable, o_busy}, 32'd6);
    chk("lock_freq", o_lock_freq, FMEAS);
    chk("lock_nco", o_nco_freq, 32'd120);

    // LOSS_COUNT-1 bad cycles, then one good cycle: still locked.
    i_freq_measured = 32'h1111_2222;
    i_amplitude = 16'd0;
    for (int j = 0; j < LS - 1; j++) tick();
    i_amplitude = 16'd600;
    tick();
    chk("loss_short_state", 32'(o_state), 32'(LOCKED));
    i_amplitude = 16'd0;
    for (int j = 0; j < LS - 1; j++) begin
      tick();
      chk("loss_partial_state", 32'(o_state), 32'(LOCKED));
    end
    tick();
    chk("loss_state", 32'(o_state), 32'(SETTLE));
    chk("loss_flags", {30'd0, o_locked, o_loop_enable}, 32'd0);
    chk("loss_nco", o_nco_freq, 32'd100);
    chk("loss_lockf_hold", o_lock_freq, FMEAS);

    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("stop_state", 32'(o_state), 32'(IDLE));
    chk("stop_nco_hold", o_nco_freq, 32'd100);
    chk("stop_busy", 32'(o_busy), 32'd0);

    // Same sweep with no signal: ends on the exact stop value, then FAIL.
    cfg(32'd100, 32'd130, 32'd10, 16'd4, 16'd500);
    i_amplitude = 16'd0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dwell(32'd100 + 32'(10 * k), $sformatf("swB%0d", k));
      tick();
    end
    chk("nosig_state", 32'(o_state), 32'(FAILS));
    chk("nosig_nco", o_nco_freq, 32'd130);
    chk("nosig_flags", {29'd0, o_fail, o_busy, o_loop_enable}, 32'd4);

    // Carry out of the frequency word on the first MEASURE.
    cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd4, 16'd500);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("carry_fail_cleared", 32'(o_fail), 32'd0);
    dwell(32'hFFFF_FFF0, "carry");
    tick();
    chk("carry_state", 32'(o_state), 32'(FAILS));
    chk("carry_nco", o_nco_freq, 32'hFFFF_FFF0);

    // Reset during SETTLE overrides a simultaneous Start and Stop.
    cfg(32'd100, 32'd130, 32'd10, 16'd4, 16'd500);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    chk("pre_rst_state", 32'(o_state), 32'(SETTLE));
    i_rst_n = 1'b0; i_start = 1'b1; i_stop = 1'b1;
    tick();
    chk("mid_rst_state", 32'(o_state), 32'(IDLE));
    chk("mid_rst_nco", o_nco_freq, 32'd0);
    chk("mid_rst_lockf", o_lock_freq, 32'd0);
    chk("mid_rst_flags", {28'd0, o_loop_enable, o_locked, o_busy, o_fail}, 32'd0);
    i_rst_n = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    tick();
    chk("post_rst_state", 32'(o_state), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
